// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
// Optional feature macro: FETCH_WRAP_TRAP_EN (wrap-around trap with sticky Fault).
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 9;

  // Highest ROM address; issuing from here is the wrap point.
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // One prefetched word together with the address it came from.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // RUN: issuing this cycle. HOLD: no issue (disabled, no space or trapped).
  // REDIRECT: the cycle following a taken branch.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // Sequential PC step, 8-bit modulo.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch unit and its environment (program ROM + decoder).
// Fault exists only when FETCH_WRAP_TRAP_EN is defined.
interface fetch_if;
  import fetch_pkg::*;

  logic                Enable;
  logic [ADDR_W-1:0]   Direccion_Instrucciones;
  logic [INSTR_W-1:0]  Instruccion;
  logic                Salto;
  logic [ADDR_W-1:0]   Destino_Salto;
  logic                Instr_Valid;
  logic [INSTR_W-1:0]  Instr_Out;
  logic [ADDR_W-1:0]   Instr_PC;
  logic                Instr_Ready;
`ifdef FETCH_WRAP_TRAP_EN
  logic                Fault;
`endif

`ifdef FETCH_WRAP_TRAP_EN
  modport master (
    input  Enable, Instruccion, Salto, Destino_Salto, Instr_Ready,
    output Direccion_Instrucciones, Instr_Valid, Instr_Out, Instr_PC, Fault
  );
  modport slave (
    output Enable, Instruccion, Salto, Destino_Salto, Instr_Ready,
    input  Direccion_Instrucciones, Instr_Valid, Instr_Out, Instr_PC, Fault
  );
`else
  modport master (
    input  Enable, Instruccion, Salto, Destino_Salto, Instr_Ready,
    output Direccion_Instrucciones, Instr_Valid, Instr_Out, Instr_PC
  );
  modport slave (
    output Enable, Instruccion, Salto, Destino_Salto, Instr_Ready,
    input  Direccion_Instrucciones, Instr_Valid, Instr_Out, Instr_PC
  );
`endif

endinterface

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {addr, instr}. Flush empties it and drops a
// same-cycle push; pop on empty is ignored; push+pop on full is legal.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_eff, pop_eff;

  fetch_entry_t entries [QDEPTH];

  assign pop_eff  = pop & (count_q != 2'd0);
  assign push_eff = push & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi = gi + 1) begin : g_slot
      fetch_entry_t entry_q, entry_d;
      logic         wr_hit;

      assign wr_hit = push_eff & (wr_ptr_q == 1'(gi));

      // Slot contents: capture the pushed word when the write pointer aims here
      always_comb begin
        entry_d = entry_q;
        if (wr_hit) begin
          entry_d = push_data;
        end
      end

      // Slot storage register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  // Pointer and occupancy update; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_eff) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = entries[rd_ptr_q];
  assign count = count_q;

  // The issue side reserves a slot before fetching, so a push can only meet
  // a full queue when the decoder pops in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_eff && !pop_eff && (count_q == 2'(QDEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC, ROM address issue, one-deep in-flight
// tracking, 2-entry prefetch queue and branch redirect/flush.
// Optional feature macro: FETCH_WRAP_TRAP_EN -- issuing from 8'hFF raises a
// sticky Fault and stops issue until Salto or Rst; otherwise the PC wraps.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic    Clk,
  input  logic    Rst,
  fetch_if.master bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;

  logic              q_push, q_pop, q_valid;
  logic [1:0]        q_count;
  logic [2:0]        occupancy;
  logic              space_ok;
  logic              trap_block;
  fetch_entry_t      q_push_data, q_head;

`ifdef FETCH_WRAP_TRAP_EN
  logic              fault_q, fault_d;
`endif

  assign q_valid = (q_count != 2'd0);
  assign q_pop   = q_valid & bus.Instr_Ready;

  // Occupancy once this cycle's pop and return have landed; a new issue
  // needs a free slot for its word to arrive into next cycle.
  assign occupancy = {1'b0, q_count} - {2'b00, q_pop} + {2'b00, inflight_q};
  assign space_ok  = (occupancy < 3'(QDEPTH));

  // A return can never be outstanding during REDIRECT; gating on it keeps a
  // stale capture from slipping in should that ever change.
  assign q_push      = inflight_q & (state_q != REDIRECT);
  assign q_push_data = '{addr: tag_q, instr: bus.Instruccion};

`ifdef FETCH_WRAP_TRAP_EN
  assign trap_block = fault_q | (inflight_q & (tag_q == ADDR_MAX));
`else
  assign trap_block = 1'b0;
`endif

  // Next-state and issue decision: branch redirect beats everything, then issue
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (bus.Salto) begin
      state_d = REDIRECT;
      pc_d    = bus.Destino_Salto;
    end else if (bus.Enable && space_ok && !trap_block) begin
      state_d    = RUN;
      addr_d     = pc_q;
      tag_d      = pc_q;
      inflight_d = 1'b1;
      pc_d       = next_pc(pc_q);
`ifdef FETCH_WRAP_TRAP_EN
      if (pc_q == ADDR_MAX) begin
        pc_d = pc_q;
      end
`endif
    end else begin
      state_d = HOLD;
    end
  end

  // PC, ROM address, in-flight flag/tag and FSM state registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FETCH_WRAP_TRAP_EN
  // Sticky wrap fault: set when the 8'hFF word is queued, cleared by a branch
  always_comb begin
    fault_d = fault_q;
    if (bus.Salto) begin
      fault_d = 1'b0;
    end else if (q_push && (tag_q == ADDR_MAX)) begin
      fault_d = 1'b1;
    end
  end

  // Fault register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign bus.Fault = fault_q;
`endif

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (Clk),
    .rst       (Rst),
    .flush     (bus.Salto),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign bus.Direccion_Instrucciones = addr_q;
  assign bus.Instr_Valid             = q_valid;
  assign bus.Instr_Out               = q_valid ? q_head.instr : '0;
  assign bus.Instr_PC                = q_valid ? q_head.addr  : '0;

endmodule
